// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 packet dispatcher.
//   NCH          : number of output channels
//   CH_W         : channel index width
//   disp_state_t : IDLE = no open packet, PKT = packet locked to a channel
package demux_pkg;
  localparam int NCH  = 4;
  localparam int CH_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } disp_state_t;
endpackage

// File: rtl/demux_1to4_dispatcher_rr_pick4.sv
// Round-robin pick among four channels (combinational).
//   mask  in  4 : candidate channels
//   last  in  2 : previously granted channel; search starts at last+1
//   grant out 2 : first set mask bit in order last+1, +2, +3, +4 (mod 4)
//   any   out 1 : mask has at least one bit set
module rr_pick4
  import demux_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [CH_W-1:0] last,
  output logic [CH_W-1:0] grant,
  output logic            any
);

  logic [CH_W-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    // k=4 wraps to last itself, so the previous owner is searched last.
    for (int k = 1; k <= NCH; k++) begin
      idx = last + CH_W'(k);
      if (!any && mask[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_1to4_dispatcher.sv
// Packet-level round-robin dispatcher in front of a 1-to-4 demux.
// Each whole packet (first beat .. s_last) is steered to one channel chosen
// round-robin from chan_en at packet start. One registered output stage.
//   clk, rst          : clock, synchronous active-high reset
//   chan_en  in  4    : channel enable mask, sampled only at packet start
//   s_valid/s_ready/s_data/s_last : input beat stream
//   m_valid  out 4    : one-hot valid for the channel owning the output register
//   m_ready  in  4    : per-channel ready; only m_ready[sel] matters
//   m_data/m_last out : presented beat (shared demux din)
//   sel      out 2    : demux select
//   busy     out 1    : packet open (first beat accepted, last not yet)
module demux_1to4_dispatcher
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    chan_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [NCH-1:0]    m_valid,
  input  logic [NCH-1:0]    m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CH_W-1:0]   sel,
  output logic              busy
);

  disp_state_t     state, state_nxt;
  logic [CH_W-1:0] cur_ch, last_grant;
  logic            out_valid;

  logic [CH_W-1:0] pick;
  logic            pick_any;
  logic            free, acc;
  logic [CH_W-1:0] ch_use;

  rr_pick4 u_pick (
    .mask  (chan_en),
    .last  (last_grant),
    .grant (pick),
    .any   (pick_any)
  );

  // Output register can take a new beat in the same cycle it drains.
  assign free    = !out_valid || m_ready[sel];
  assign s_ready = free && ((state == PKT) || pick_any);
  assign acc     = s_valid && s_ready;
  assign ch_use  = (state == IDLE) ? pick : cur_ch;
  assign busy    = (state == PKT);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_mv
      assign m_valid[gi] = out_valid && (sel == CH_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) state_nxt = s_last ? IDLE : PKT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      sel        <= '0;
      cur_ch     <= '0;
      last_grant <= CH_W'(NCH - 1);
    end else if (acc) begin
      out_valid <= 1'b1;
      m_data    <= s_data;
      m_last    <= s_last;
      sel       <= ch_use;
      if (state == IDLE) begin
        cur_ch     <= pick;
        last_grant <= pick;
      end
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux_1to4_dispatcher.sv
module tb_demux_1to4_dispatcher;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] chan_en;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic [3:0] m_valid;
  logic [3:0] m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [1:0] sel;
  logic       busy;

  int total = 0;
  int bad   = 0;

  demux_1to4_dispatcher #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .chan_en(chan_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
  endtask

  task automatic outchk(input string tag, input logic [3:0] mv, input logic [7:0] md,
                        input logic ml, input logic b);
    chk({tag, "_mvalid"}, 32'(m_valid), 32'(mv));
    chk({tag, "_mdata"},  32'(m_data),  32'(md));
    chk({tag, "_mlast"},  32'(m_last),  32'(ml));
    chk({tag, "_busy"},   32'(busy),    32'(b));
  endtask

  initial begin
    rst = 1'b1; chan_en = 4'h0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 4'h0;
    tick(); tick();
    outchk("reset", 4'b0000, 8'h00, 1'b0, 1'b0);
    chk("reset_sel", 32'(sel), 32'd0);
    rst = 1'b0;

    // Five single-beat packets back-to-back, rotating 0,1,2,3,0.
    chan_en = 4'hF; m_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      beat(8'hA0 + 8'(i), 1'b1);
      chk("rr_sready", 32'(s_ready), 32'd1);
      tick();
      outchk("rr", 4'b0001 << (i % 4), 8'hA0 + 8'(i), 1'b1, 1'b0);
      chk("rr_sel", 32'(sel), 32'(i % 4));
    end
    s_valid = 1'b0;
    tick();
    chk("rr_drain", 32'(m_valid), 32'd0);

    // chan_en=1010, last grant 0 -> ch1; then 1-beat packet -> ch3. Stall ch1 3 clks.
    chan_en = 4'b1010;
    beat(8'h11, 1'b0);
    chk("p2_sready0", 32'(s_ready), 32'd1);
    tick();
    outchk("p2_b11", 4'b0010, 8'h11, 1'b0, 1'b1);
    chk("p2_sel", 32'(sel), 32'd1);
    beat(8'h22, 1'b0);
    tick();
    outchk("p2_b22", 4'b0010, 8'h22, 1'b0, 1'b1);
    m_ready = 4'b1101;
    beat(8'h33, 1'b1);
    chk("stall_sready", 32'(s_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      outchk("stall_hold", 4'b0010, 8'h22, 1'b0, 1'b1);
      chk("stall_sready_h", 32'(s_ready), 32'd0);
    end
    m_ready = 4'hF;
    #1;
    chk("unstall_sready", 32'(s_ready), 32'd1);
    tick();
    outchk("p2_b33", 4'b0010, 8'h33, 1'b1, 1'b0);
    beat(8'h44, 1'b1);
    tick();
    outchk("p3_b44", 4'b1000, 8'h44, 1'b1, 1'b0);
    chk("p3_sel", 32'(sel), 32'd3);

    // Mid-packet enable change: last grant 3 -> ch0 first.
    chan_en = 4'hF;
    beat(8'h50, 1'b1);
    tick();
    outchk("mc_b50", 4'b0001, 8'h50, 1'b1, 1'b0);
    beat(8'h55, 1'b0);
    tick();
    outchk("mc_b55", 4'b0010, 8'h55, 1'b0, 1'b1);
    chan_en = 4'b0001;
    beat(8'h66, 1'b1);
    chk("mc_sready", 32'(s_ready), 32'd1);
    tick();
    outchk("mc_b66", 4'b0010, 8'h66, 1'b1, 1'b0);
    beat(8'h77, 1'b1);
    tick();
    outchk("mc_b77", 4'b0001, 8'h77, 1'b1, 1'b0);

    // Pending beat on ch1 (last grant 0 -> 1), then chan_en=0 blocks input.
    chan_en = 4'hF;
    beat(8'h99, 1'b1);
    tick();
    outchk("z_b99", 4'b0010, 8'h99, 1'b1, 1'b0);
    chan_en = 4'h0;
    beat(8'h88, 1'b1);
    chk("z_sready0", 32'(s_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("z_mvalid", 32'(m_valid), 32'd0);
      chk("z_sready", 32'(s_ready), 32'd0);
    end

    // Reset mid 4-beat packet: last grant 1 -> ch2.
    chan_en = 4'hF;
    beat(8'hC1, 1'b0);
    tick();
    outchk("r_c1", 4'b0100, 8'hC1, 1'b0, 1'b1);
    beat(8'hC2, 1'b0);
    tick();
    outchk("r_c2", 4'b0100, 8'hC2, 1'b0, 1'b1);
    rst = 1'b1;
    beat(8'hC3, 1'b0);
    tick();
    rst = 1'b0;
    chk("r_mvalid", 32'(m_valid), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_sel", 32'(sel), 32'd0);
    beat(8'hD0, 1'b1);
    tick();
    outchk("r_d0", 4'b0001, 8'hD0, 1'b1, 1'b0);
    chk("r_d0_sel", 32'(sel), 32'd0);
    s_valid = 1'b0;
    tick();
    chk("end_drain", 32'(m_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
